// File: rtl/mont_convert_out.sv
// Word-serial Montgomery reduction: converts a Montgomery-domain residue a*R mod n
// back to a mod n (R = 2^(WIDTH*S)) using a single WIDTH x WIDTH multiplier.
module mont_convert_out #(
  parameter int WIDTH = 32,
  parameter int S     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [S-1:0][WIDTH-1:0] a,
  input  logic [S-1:0][WIDTH-1:0] n,
  input  logic [WIDTH-1:0]        n_prime,
  output logic [S-1:0][WIDTH-1:0] result,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam int CW = $clog2(S + 1);
  localparam logic [IW-1:0] LAST   = IW'(S - 1);
  localparam logic [CW-1:0] ROUNDS = CW'(S);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MQ     = 3'd1;
  localparam logic [2:0] ST_ACC    = 3'd2;
  localparam logic [2:0] ST_SUB    = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  logic [2:0]              state;
  logic [S-1:0][WIDTH-1:0] n_q;
  logic [WIDTH-1:0]        np_q;
  logic [S-1:0][WIDTH-1:0] t;
  logic                    t_s;
  logic [S-1:0][WIDTH-1:0] d;
  logic [WIDTH-1:0]        m;
  logic [WIDTH:0]          carry;
  logic                    borrow;
  logic [IW-1:0]           j;
  logic [CW-1:0]           i;

  // Word-j datapath shared by the accumulate and subtract phases.
  logic [WIDTH-1:0]        t_j;
  logic [WIDTH-1:0]        n_j;
  logic [2*WIDTH-1:0]      prod;
  logic [2*WIDTH:0]        acc_sum;
  logic [WIDTH-1:0]        acc_w;
  logic [WIDTH:0]          acc_c;
  logic [WIDTH:0]          top_sum;
  logic [WIDTH:0]          sub_diff;
  logic                    final_borrow;
  logic [S-1:0][WIDTH-1:0] t_nxt;
  logic [S-1:0][WIDTH-1:0] d_nxt;

  assign t_j     = t[j];
  assign n_j     = n_q[j];
  assign prod    = (2*WIDTH)'(m) * (2*WIDTH)'(n_j);
  assign acc_sum = (2*WIDTH+1)'(t_j) + (2*WIDTH+1)'(prod) + (2*WIDTH+1)'(carry);
  assign acc_w   = acc_sum[WIDTH-1:0];
  assign acc_c   = acc_sum[2*WIDTH:WIDTH];
  assign top_sum = acc_c + (WIDTH+1)'(t_s);

  assign sub_diff     = (WIDTH+1)'(t_j) - (WIDTH+1)'(n_j) - (WIDTH+1)'(borrow);
  assign final_borrow = sub_diff[WIDTH];

  // Accumulate shifts t down one word: word j lands in slot j-1, word 0 is dropped.
  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    t_nxt = t;
    if (j != '0) t_nxt[j - IW'(1)] = acc_w;
    if (j == LAST) t_nxt[LAST] = top_sum[WIDTH-1:0];
  end

  always_comb begin
    d_nxt    = d;
    d_nxt[j] = sub_diff[WIDTH-1:0];
  end

  assign busy = (state == ST_MQ) || (state == ST_ACC) || (state == ST_SUB);
  assign done = (state == ST_COMMIT);

  // NOTE: all state here is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      n_q    <= '0;
      np_q   <= '0;
      t      <= '0;
      t_s    <= 1'b0;
      d      <= '0;
      m      <= '0;
      carry  <= '0;
      borrow <= 1'b0;
      j      <= '0;
      i      <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q   <= n;
            np_q  <= n_prime;
            t     <= a;
            t_s   <= 1'b0;
            i     <= '0;
            state <= ST_MQ;
          end
        end
        ST_MQ: begin
          m     <= t[0] * np_q;
          j     <= '0;
          carry <= '0;
          state <= ST_ACC;
        end
        ST_ACC: begin
          t     <= t_nxt;
          carry <= acc_c;
          if (j == LAST) begin
            t_s    <= top_sum[WIDTH];
            i      <= i + CW'(1);
            j      <= '0;
            borrow <= 1'b0;
            state  <= ((i + CW'(1)) == ROUNDS) ? ST_SUB : ST_MQ;
          end else begin
            j <= j + IW'(1);
          end
        end
        ST_SUB: begin
          d      <= d_nxt;
          borrow <= final_borrow;
          if (j == LAST) begin
            // t >= n (or t overflowed past R) selects the difference.
            result <= (t_s || !final_borrow) ? d_nxt : t;
            state  <= ST_COMMIT;
          end else begin
            j <= j + IW'(1);
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_convert_out.sv
// Self-checking bench for mont_convert_out: S=1 and S=8 instances, directed tables,
// handshake corner cases and random vectors against a modular-halving reference.
module tb_mont_convert_out;

  localparam int L1 = 4;
  localparam int L8 = 81;

  logic clk = 1'b0;
  logic rst;

  logic             start1, busy1, done1;
  logic [0:0][31:0] a1, n1, res1;
  logic [31:0]      np1;

  logic             start8, busy8, done8;
  logic [7:0][31:0] a8, n8, res8;
  logic [31:0]      np8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mont_convert_out #(.WIDTH(32), .S(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .n(n1), .n_prime(np1),
    .result(res1), .busy(busy1), .done(done1)
  );

  mont_convert_out #(.WIDTH(32), .S(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .n(n8), .n_prime(np8),
    .result(res8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp;
  } vec1_t;

  typedef struct {
    logic [255:0] a;
    logic [255:0] exp;
  } vec8_t;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // a * 2^(-bits) mod n by repeated modular halving (n odd).
  function automatic logic [255:0] ref_model(input logic [255:0] av, input logic [255:0] nv,
                                             input int bits);
    logic [256:0] x;
    x = {1'b0, av % nv};
    for (int k = 0; k < bits; k++)
      x = x[0] ? ((x + {1'b0, nv}) >> 1) : (x >> 1);
    return x[255:0];
  endfunction

  function automatic logic [31:0] nprime_of(input logic [31:0] n0);
    logic [31:0] x;
    x = n0;
    for (int k = 0; k < 5; k++) x = x * (32'd2 - n0 * x);
    return -x;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a falling edge; start is sampled by the following rising edge (cycle 0).
  task automatic op1(input logic [31:0] av, input logic [31:0] nv, input logic [31:0] npv,
                     input logic [31:0] expv, input string nm);
    int k;
    bit busy_ok;
    bit got;
    a1 = av; n1 = nv; np1 = npv; start1 = 1'b1;
    busy_ok = 1'b1; got = 1'b0;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 1'b0; a1 = ~av; n1 = ~nv; np1 = ~npv;
      end
      if (done1) begin
        got = 1'b1;
        break;
      end
      if (!busy1) busy_ok = 1'b0;
    end
    check({nm, "_latency"}, got ? k : 0, L1);
    check({nm, "_busy"}, {busy_ok, busy1}, 2'b10);
    check({nm, "_result"}, res1, expv);
    @(negedge clk);
    check({nm, "_done_pulse"}, {done1, busy1}, 2'b00);
  endtask

  // p1/p2: cycles at which a stray start is pulsed; rst_at: cycle at which reset is applied.
  task automatic op8(input logic [255:0] av, input logic [255:0] nv, input logic [31:0] npv,
                     input logic [255:0] expv, input string nm,
                     input int p1, input int p2, input int rst_at);
    int k;
    bit busy_ok;
    bit got;
    bit aborted;
    a8 = av; n8 = nv; np8 = npv; start8 = 1'b1;
    busy_ok = 1'b1; got = 1'b0; aborted = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      start8 = (k == p1) || (k == p2);
      if (k == 1) begin
        a8 = ~av; n8 = ~nv; np8 = ~npv;
      end
      if (k == rst_at) begin
        rst = 1'b0;
        #1;
        check({nm, "_rst_outputs"}, {res8, busy8, done8}, '0);
        start8 = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done8) begin
        got = 1'b1;
        break;
      end
      if (!busy8) busy_ok = 1'b0;
    end
    if (!aborted) begin
      check({nm, "_latency"}, got ? k : 0, L8);
      check({nm, "_busy"}, {busy_ok, busy8}, 2'b10);
      check({nm, "_result"}, res8, expv);
      @(negedge clk);
      check({nm, "_done_pulse"}, {done8, busy8}, 2'b00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec1_t        tbl1[4];
    vec8_t        tbl8[4];
    bit           idle_ok;
    bit           no_done;
    logic [255:0] nv, av;
    logic [31:0]  np_small;

    tbl1[0] = '{32'd256,   32'd1};
    tbl1[1] = '{32'd512,   32'd2};
    tbl1[2] = '{32'd65792, 32'd257};
    tbl1[3] = '{32'd0,     32'd0};

    tbl8[0] = '{256'd65536,  256'd1};
    tbl8[1] = '{256'd131072, 256'd2};
    tbl8[2] = '{256'd0,      256'd0};
    tbl8[3] = '{256'd65793,  256'd0};

    rst = 1'b0; start1 = 1'b0; start8 = 1'b0;
    a1 = '0; n1 = '0; np1 = '0; a8 = '0; n8 = '0; np8 = '0;
    repeat (3) @(negedge clk);
    check("reset_s8", {res8, busy8, done8}, '0);
    check("reset_s1", {res1, busy1, done1}, '0);

    rst = 1'b1;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (res8 != '0 || busy8 || done8 || res1 != '0 || busy1 || done1) idle_ok = 1'b0;
    end
    check("idle_20_cycles", idle_ok, 1'b1);

    for (int v = 0; v < 4; v++)
      op1(tbl1[v].a, 32'd65793, 32'hFF0000FF, tbl1[v].exp, $sformatf("s1_tbl%0d", v));

    for (int v = 0; v < 4; v++)
      op8(tbl8[v].a, 256'd65793, 32'hFF0000FF, tbl8[v].exp, $sformatf("s8_tbl%0d", v),
          -1, -1, -1);

    // Stray starts while busy, then an immediate back-to-back start.
    nv = rand256(); nv[0] = 1'b1; nv[255] = 1'b1;
    av = rand256() % nv;
    op8(av, nv, nprime_of(nv[31:0]), ref_model(av, nv, 256), "midop_start", 10, 40, -1);
    av = rand256() % nv;
    op8(av, nv, nprime_of(nv[31:0]), ref_model(av, nv, 256), "back_to_back", -1, -1, -1);

    // Reset in the middle of an operation.
    av = rand256() % nv;
    op8(av, nv, nprime_of(nv[31:0]), ref_model(av, nv, 256), "midop_rst", -1, -1, 30);
    no_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done8 || busy8 || res8 != '0) no_done = 1'b0;
    end
    check("rst_hold_quiet", no_done, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    op8(av, nv, nprime_of(nv[31:0]), ref_model(av, nv, 256), "after_rst", -1, -1, -1);

    // Out-of-range operands: a = n and a = 2^256-1 still reduce fully.
    op8(nv, nv, nprime_of(nv[31:0]), ref_model(nv, nv, 256), "a_eq_n", -1, -1, -1);
    av = '1;
    op8(av, nv, nprime_of(nv[31:0]), ref_model(av, nv, 256), "a_all_ones", -1, -1, -1);

    for (int v = 0; v < 500; v++) begin
      nv = rand256();
      nv[0] = 1'b1;
      if (v % 2 == 1) nv[255:224] = nv[255:224] | 32'hF000_0000;
      if (nv[255:224] == '0) nv[224] = 1'b1;
      if (v % 4 == 3) av = nv - 256'd1 - 256'($urandom_range(0, 15));
      else            av = rand256() % nv;
      op8(av, nv, nprime_of(nv[31:0]), ref_model(av, nv, 256), $sformatf("rand8_%0d", v),
          -1, -1, -1);
    end

    for (int v = 0; v < 50; v++) begin
      nv = '0;
      nv[31:0] = $urandom | 32'd1;
      np_small = nprime_of(nv[31:0]);
      av = '0;
      av[31:0] = $urandom % nv[31:0];
      op1(av[31:0], nv[31:0], np_small, ref_model(av, nv, 32), $sformatf("rand1_%0d", v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_convert_out.md
# mont_convert_out

Word-serial Montgomery reduction stage sitting directly downstream of `montexp`. It takes a Montgomery-domain residue `a·R mod n` and returns the ordinary residue `a mod n` by computing `a·R⁻¹ mod n` with `R = 2^(WIDTH·S)`, using one WIDTH×WIDTH multiplier. It accepts `montexp`'s `result`/`n`/`n_prime` buses unchanged and feeds the Paillier L-function and decryption logic.

## Interface
- `WIDTH`, 32, word width in bits; also the width of `n_prime`.
- `S`, 8, number of words per operand; word 0 is least significant.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `a`  input  WIDTH×[S]  Montgomery-domain value; must satisfy `a < n`.
- `n`  input  WIDTH×[S]  odd modulus.
- `n_prime`  input  WIDTH  `−n⁻¹ mod 2^WIDTH`.
- `result`  output  WIDTH×[S]  `a·R⁻¹ mod n`, fully reduced (`< n`).
- `busy`  output  1  high from the cycle after `start` is accepted until `done`.
- `done`  output  1  one-cycle pulse; `result` valid from this cycle on.

## Operation
- Reset (`rst` low): state IDLE; `result` all words 0, `busy` 0, `done` 0, internal `t`, counters, carry and borrow cleared. Takes effect immediately, including mid-operation; no partial result is ever exposed.
- IDLE: on `start`=1, capture `a`, `n`, `n_prime` into registers (inputs are don't-care afterwards); load `t ← a`, extra top bit `t_S ← 0`, `i ← 0`; go to MQ.
- MQ (1 cycle): `m ← (t[0]·n_prime) mod 2^WIDTH`; `j ← 0`, carry ← 0; go to ACC.
- ACC (S cycles, j = 0..S−1): `{c, w} = t[j] + m·n[j] + carry` (2·WIDTH+1-bit sum, no overflow); for j>0 write `t[j−1] ← w`; j=0 result word is discarded (zero by construction). On j=S−1 also write `t[S−1] ← carry_out + t_S` low word, `t_S ←` its overflow bit. Then `i ← i+1`; if `i = S` go to SUB, else MQ.
- SUB (S cycles, word-serial): `d[k] = t[k] − n[k] − borrow`, held in a separate register; final borrow recorded.
- COMMIT (1 cycle): if `t_S = 1` or final borrow = 0, `result ← d`, else `result ← t`. Assert `done`, go to IDLE.
- `start` while busy is ignored (not queued). `start` in the COMMIT cycle is ignored; `start` in the cycle after `done` is accepted.
- `result` holds its value until the next COMMIT or reset; it is not cleared on a new `start`.
- Inputs violating `a < n` or `n` odd: result undefined, but timing and handshake unchanged.

## Timing
- Total latency: `done` is high in the (S+1)²-th cycle after the edge that sampled `start` (S·(S+1) reduction cycles + S subtract cycles + 1 commit); 81 cycles for S=8, 4 for S=1.
- Latency is data-independent.
- `busy` falls in the same edge that raises `done`... precisely: `busy` is 1 for cycles 1..(S+1)²−1 and 0 in the `done` cycle.
- Back-to-back throughput: one conversion per (S+1)²+1 cycles.
- Critical path: one WIDTH×WIDTH multiply plus two adds; no multiplier pipelining.

## Test plan
- Reset: hold `rst` low, toggle clock → `result`=0, `busy`=0, `done`=0; release, no `start` for 20 cycles → outputs unchanged.
- S=1, WIDTH=32, n=65793, n_prime=0xFF0000FF: a=256 → result=1; a=512 → 2; a=65792 → 257; a=0 → 0; `done` exactly 4 cycles after `start` edge.
- S=8, WIDTH=32, n[0]=65793, n[1..7]=0, n_prime=0xFF0000FF: a[0]=65536, rest 0 → result[0]=1, rest 0; `done` at cycle 81; `busy` high cycles 1–80.
- Random odd multi-word n (S=8, top word nonzero) and a<n, 500 vectors vs. reference model `a·2^(−256) mod n`; coverage must hit both COMMIT selections (subtraction taken and not taken) and `t_S`=1.
- `start` pulsed at cycles 10 and 40 of an operation → ignored, single `done`, result correct; `start` the cycle after `done` → accepted, second result correct.
- `rst` asserted at cycle 30 of an 81-cycle operation → outputs 0 immediately, no `done`; new `start` after release → correct result at full latency.
